// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: width helpers
// for pointer/occupancy sizing and an encoding of the per-cycle access type.
package fifo_pkg;

    // Access kind seen in one cycle, encoded as {write accepted, read accepted}.
    typedef enum logic [1:0] {
        ACC_NONE = 2'b00,
        ACC_RD   = 2'b01,
        ACC_WR   = 2'b10,
        ACC_BOTH = 2'b11
    } fifo_acc_e;

    // Defaults matching the original fixed 8-bit / 64-entry buffer.
    localparam int unsigned FIFO_DEF_DATA_W     = 32'd8;
    localparam int unsigned FIFO_DEF_DEPTH      = 32'd64;
    localparam int unsigned FIFO_DEF_AFULL_LVL  = 32'd60;
    localparam int unsigned FIFO_DEF_AEMPTY_LVL = 32'd4;

    // Ceiling log2 that never returns 0, so a pointer is always at least one bit wide.
    function automatic int unsigned safe_clog2(input int unsigned n);
        int unsigned w;
        w = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = 32'(i + 1);
            end
        end
        if (w == 32'd0) begin
            w = 32'd1;
        end
        return w;
    endfunction

    // Occupancy counter width: one extra bit so the value DEPTH is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return safe_clog2(depth) + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage array for the FIFO: synchronous write port and a
// registered read port with read enable. The read register clears on reset;
// the array itself is never reset.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_W = FIFO_DEF_DATA_W,
    parameter  int unsigned DEPTH  = FIFO_DEF_DEPTH,
    localparam int unsigned AW     = safe_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Store incoming data at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Capture the addressed word on a read; a same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// levels, a read-data valid strobe and defined simultaneous read/write at the
// full and empty boundaries.
// Optional feature: define FIFO_ERR_FLAGS_EN to enable the sticky
// overflow/underflow flags (cleared by err_clr); otherwise they read 0.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_W     = FIFO_DEF_DATA_W,
    parameter  int unsigned DEPTH      = FIFO_DEF_DEPTH,
    parameter  int unsigned AFULL_LVL  = FIFO_DEF_AFULL_LVL,
    parameter  int unsigned AEMPTY_LVL = FIFO_DEF_AEMPTY_LVL,
    localparam int unsigned CNT_W      = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] buf_out,
    output logic              rd_valid,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  fifo_counter,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PTR_W = safe_clog2(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_rd_valid;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_acc;
    logic             w_rd_acc;
    fifo_acc_e        w_acc;

    // Status decodes from the registered occupancy.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // A read needs data; a write needs room, or a same-cycle read freeing a slot.
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);
    assign w_acc    = fifo_acc_e'({w_wr_acc, w_rd_acc});

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .wr_data (buf_in),
        .rd_en   (w_rd_acc),
        .rd_addr (r_rd_ptr),
        .rd_data (buf_out)
    );

    // Advance read/write pointers on accepted accesses; power-of-two depth wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Next occupancy: up on write only, down on read only, hold otherwise.
    always_comb begin
        w_count_nxt = r_count;
        case (w_acc)
            ACC_WR:   w_count_nxt = r_count + CNT_W'(1);
            ACC_RD:   w_count_nxt = r_count - CNT_W'(1);
            ACC_BOTH: w_count_nxt = r_count;
            ACC_NONE: w_count_nxt = r_count;
            default:  w_count_nxt = r_count;
        endcase
    end

    // Occupancy register and read-valid strobe (one cycle after an accepted read).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_rd_valid <= w_rd_acc;
        end
    end

    assign fifo_counter = r_count;
    assign rd_valid     = r_rd_valid;
    assign buf_empty    = w_empty;
    assign buf_full     = w_full;
    assign almost_empty = (r_count <= CNT_W'(AEMPTY_LVL));
    assign almost_full  = (r_count >= CNT_W'(AFULL_LVL));

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky rejection flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (err_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en & ~w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (rd_en & ~w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_err_clr_unused;

    // Error reporting compiled out: flags constant, clear input has no effect.
    assign w_err_clr_unused = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a default-parameter instance (8x64)
// and a small instance (16x4, AFULL 3, AEMPTY 1). Reads push their expected
// data into a queue; a monitor branch pops and compares on every rd_valid.
module tb_fifo_sync_param;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk;

    logic        rst_a, wr_a, rd_a, err_clr_a;
    logic [7:0]  din_a, dout_a;
    logic        vld_a, empty_a, full_a, ae_a, af_a, ovf_a, unf_a;
    logic [6:0]  cnt_a;

    logic        rst_b, wr_b, rd_b, err_clr_b;
    logic [15:0] din_b, dout_b;
    logic        vld_b, empty_b, full_b, ae_b, af_b, ovf_b, unf_b;
    logic [2:0]  cnt_b;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    int n_checks;
    int n_pass;

    fifo_sync_param u_dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .wr_en        (wr_a),
        .buf_in       (din_a),
        .rd_en        (rd_a),
        .buf_out      (dout_a),
        .rd_valid     (vld_a),
        .buf_empty    (empty_a),
        .buf_full     (full_a),
        .almost_empty (ae_a),
        .almost_full  (af_a),
        .fifo_counter (cnt_a),
        .err_clr      (err_clr_a),
        .overflow     (ovf_a),
        .underflow    (unf_a)
    );

    fifo_sync_param #(
        .DATA_W     (16),
        .DEPTH      (4),
        .AFULL_LVL  (3),
        .AEMPTY_LVL (1)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .wr_en        (wr_b),
        .buf_in       (din_b),
        .rd_en        (rd_b),
        .buf_out      (dout_b),
        .rd_valid     (vld_b),
        .buf_empty    (empty_b),
        .buf_full     (full_b),
        .almost_empty (ae_b),
        .almost_full  (af_b),
        .fifo_counter (cnt_b),
        .err_clr      (err_clr_b),
        .overflow     (ovf_b),
        .underflow    (unf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle on instance A; ev/ed give the hand-computed read result.
    task automatic cyc_a(input logic w, input logic [7:0] d, input logic r,
                         input logic ev, input logic [7:0] ed);
        wr_a = w;
        din_a = d;
        rd_a = r;
        if (ev) qa.push_back(16'(ed));
        @(posedge clk);
        #2;
        chk("rd_valid_a", 32'(vld_a), 32'(ev));
        wr_a = 1'b0;
        rd_a = 1'b0;
    endtask

    // One cycle on instance B.
    task automatic cyc_b(input logic w, input logic [15:0] d, input logic r,
                         input logic ev, input logic [15:0] ed);
        wr_b = w;
        din_b = d;
        rd_b = r;
        if (ev) qb.push_back(ed);
        @(posedge clk);
        #2;
        chk("rd_valid_b", 32'(vld_b), 32'(ev));
        wr_b = 1'b0;
        rd_b = 1'b0;
    endtask

    // Pops expected data whenever an instance presents valid read data.
    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (vld_a) begin
                if (qa.size() == 0) begin
                    chk("sb_a_unexpected", 32'(vld_a), 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("sb_a_data", 32'(dout_a), 32'(e));
                end
            end
            if (vld_b) begin
                if (qb.size() == 0) begin
                    chk("sb_b_unexpected", 32'(vld_b), 32'd0);
                end else begin
                    e = qb.pop_front();
                    chk("sb_b_data", 32'(dout_b), 32'(e));
                end
            end
        end
    endtask

    task automatic stimulus();
        // 1: reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_empty_a", 32'(empty_a), 32'd1);
        chk("rst_ae_a", 32'(ae_a), 32'd1);
        chk("rst_full_a", 32'(full_a), 32'd0);
        chk("rst_af_a", 32'(af_a), 32'd0);
        chk("rst_dout_a", 32'(dout_a), 32'd0);
        chk("rst_vld_a", 32'(vld_a), 32'd0);
        chk("rst_ovf_a", 32'(ovf_a), 32'd0);
        chk("rst_unf_a", 32'(unf_a), 32'd0);
        chk("rst_cnt_b", 32'(cnt_b), 32'd0);
        chk("rst_dout_b", 32'(dout_b), 32'd0);
        chk("rst_ovf_b", 32'(ovf_b), 32'd0);
        chk("rst_unf_b", 32'(unf_b), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // 2: fill 0..63, then a dropped 65th write
        for (int i = 0; i < 64; i++) begin
            cyc_a(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
            chk("fill_cnt", 32'(cnt_a), 32'(i + 1));
            chk("fill_af", 32'(af_a), 32'(i >= 59));
            chk("fill_full", 32'(full_a), 32'(i == 63));
            chk("fill_ae", 32'(ae_a), 32'(i < 4));
        end
        cyc_a(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
        chk("ovf_cnt", 32'(cnt_a), 32'd64);
        chk("ovf_full", 32'(full_a), 32'd1);
        chk("ovf_flag", 32'(ovf_a), 32'(EXP_ERR));

        // 3: drain 0..63, extra read, error clear
        for (int i = 0; i < 64; i++) begin
            cyc_a(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
            chk("drain_cnt", 32'(cnt_a), 32'(63 - i));
        end
        cyc_a(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("unf_empty", 32'(empty_a), 32'd1);
        chk("unf_flag", 32'(unf_a), 32'(EXP_ERR));
        chk("ovf_sticky", 32'(ovf_a), 32'(EXP_ERR));
        err_clr_a = 1'b1;
        cyc_a(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        err_clr_a = 1'b0;
        chk("clr_ovf", 32'(ovf_a), 32'd0);
        chk("clr_unf_priority", 32'(unf_a), 32'd0);

        // 4: simultaneous read/write while full
        for (int i = 0; i < 64; i++) begin
            cyc_a(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
        end
        chk("refill_cnt", 32'(cnt_a), 32'd64);
        for (int k = 0; k < 10; k++) begin
            cyc_a(1'b1, 8'(100 + k), 1'b1, 1'b1, 8'(k));
            chk("full_rw_cnt", 32'(cnt_a), 32'd64);
            chk("full_rw_ovf", 32'(ovf_a), 32'd0);
        end
        for (int j = 0; j < 64; j++) begin
            cyc_a(1'b0, 8'h00, 1'b1, 1'b1, (j < 54) ? 8'(10 + j) : 8'(46 + j));
        end
        chk("drain2_cnt", 32'(cnt_a), 32'd0);
        chk("drain2_empty", 32'(empty_a), 32'd1);

        // 5: simultaneous read/write while empty
        cyc_a(1'b1, 8'h55, 1'b1, 1'b0, 8'h00);
        chk("empty_rw_cnt", 32'(cnt_a), 32'd1);
        chk("empty_rw_unf", 32'(unf_a), 32'(EXP_ERR));
        cyc_a(1'b0, 8'h00, 1'b1, 1'b1, 8'h55);
        chk("empty_rw_cnt2", 32'(cnt_a), 32'd0);

        // 6: small instance, wrap pointers three times
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                cyc_b(1'b1, 16'(16'h1000 + p * 16 + k), 1'b0, 1'b0, 16'h0000);
                chk("b_cnt", 32'(cnt_b), 32'(k + 1));
                chk("b_af", 32'(af_b), 32'(k >= 2));
                chk("b_ae", 32'(ae_b), 32'(k == 0));
                chk("b_full", 32'(full_b), 32'(k == 3));
            end
            for (int k = 0; k < 4; k++) begin
                cyc_b(1'b0, 16'h0000, 1'b1, 1'b1, 16'(16'h1000 + p * 16 + k));
                chk("b_drain_cnt", 32'(cnt_b), 32'(3 - k));
            end
        end
        // reset with two entries held
        cyc_b(1'b1, 16'hA001, 1'b0, 1'b0, 16'h0000);
        cyc_b(1'b1, 16'hA002, 1'b0, 1'b0, 16'h0000);
        chk("b_pre_rst_cnt", 32'(cnt_b), 32'd2);
        rst_b = 1'b1;
        cyc_b(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst_b = 1'b0;
        chk("b_rst_cnt", 32'(cnt_b), 32'd0);
        chk("b_rst_empty", 32'(empty_b), 32'd1);
        chk("b_rst_ae", 32'(ae_b), 32'd1);
        cyc_b(1'b1, 16'hB001, 1'b0, 1'b0, 16'h0000);
        cyc_b(1'b1, 16'hB002, 1'b0, 1'b0, 16'h0000);
        chk("b_post_rst_cnt", 32'(cnt_b), 32'd2);
        cyc_b(1'b0, 16'h0000, 1'b1, 1'b1, 16'hB001);
        cyc_b(1'b0, 16'h0000, 1'b1, 1'b1, 16'hB002);
        cyc_b(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("b_end_cnt", 32'(cnt_b), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        clk       = 1'b0;
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        wr_a      = 1'b0;
        rd_a      = 1'b0;
        din_a     = 8'h00;
        err_clr_a = 1'b0;
        wr_b      = 1'b0;
        rd_b      = 1'b0;
        din_b     = 16'h0000;
        err_clr_b = 1'b0;
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        chk("sb_a_left", 32'(qa.size()), 32'd0);
        chk("sb_b_left", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
